// File: rtl/pybitproc_gen.sv
// pybitproc_gen: payload bit processor between the packet controller and the air-bit modem.
//   TX (mode_tx=1): payload -> CRC append -> whitening -> zero pad -> shortened Hamming parity.
//   RX (mode_tx=0): FEC syndrome correction -> de-whitening -> CRC check; only the payload
//   bits are forwarded, CRC and pad bits are consumed internally.
// Ports:
//   clk_6M, rst (sync, active-high)
//   start + config (mode_tx, crc_en, wht_en, fec_en, crc_init, wht_init, pay_len),
//     latched by a start pulse while idle
//   in_valid/in_bit/in_ready   bit-serial input
//   out_valid/out_bit/out_ready bit-serial output (one-entry register)
//   busy, done, crc_ok, fec_corr_cnt, fec_uncorr  per-packet status
//   dbg_state                  current FSM state
// Handshake: a bit moves on a cycle where valid & ready are both high. out_valid stays high and
//   out_bit is held until accepted. in_ready is decoded from the state, the output register and
//   out_ready; it never looks at in_valid.
module pybitproc_gen #(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
  parameter int               WHT_W    = 7,
  parameter logic [WHT_W-1:0] WHT_POLY = 7'b0010001,
  parameter int               FEC_K    = 10,
  parameter int               FEC_P    = 5,
  parameter logic [FEC_P-1:0] FEC_POLY = 5'b10101,
  parameter int               LEN_W    = 12
) (
  input  logic             clk_6M,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_tx,
  input  logic             crc_en,
  input  logic             wht_en,
  input  logic             fec_en,
  input  logic [CRC_W-1:0] crc_init,
  input  logic [WHT_W-1:0] wht_init,
  input  logic [LEN_W-1:0] pay_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [7:0]       fec_corr_cnt,
  output logic             fec_uncorr,
  output logic [2:0]       dbg_state
);
  localparam int FEC_N  = FEC_K + FEC_P;
  localparam int CNT_W  = $clog2(FEC_N + 1);
  localparam int CRC_CW = $clog2(CRC_W + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INFO = 3'd1, S_PARITY = 3'd2, S_COLLECT = 3'd3, S_SYN = 3'd4, S_DRAIN = 3'd5
  } state_t;

  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] r, input logic d);
    return {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ d) ? CRC_POLY : '0);
  endfunction

  function automatic logic [WHT_W-1:0] wht_next(input logic [WHT_W-1:0] w);
    return {w[WHT_W-2:0], 1'b0} ^ (w[WHT_W-1] ? WHT_POLY : '0);
  endfunction

  function automatic logic [FEC_P-1:0] fec_next(input logic [FEC_P-1:0] r, input logic d);
    return {r[FEC_P-2:0], 1'b0} ^ ((r[FEC_P-1] ^ d) ? FEC_POLY : '0);
  endfunction

  state_t state, state_nxt;

  logic cfg_tx, cfg_crc, cfg_wht, cfg_fec;
  logic [CRC_W-1:0]  crc_r;
  logic [WHT_W-1:0]  wht_r;
  logic [FEC_P-1:0]  fec_r, par_r, syn, pw;
  logic [FEC_N-1:0]  cw, flip_mask;
  logic              flip_hit;
  logic [LEN_W-1:0]  pay_rem, pay_rem_n;
  logic [CRC_CW-1:0] crc_rem, crc_rem_n;
  logic [CNT_W-1:0]  blk_cnt, par_cnt, col_cnt;

  logic ph_data, ph_crc, ph_pad, out_free, info_from_in, info_step, par_step, col_step;
  logic blk_last, info_left, info_left_n, raw_bit, wht_bit, info_x, emit, pkt_empty, drain_done;

  // Info-bit phase is decoded from the remaining counts: payload first, then CRC, then pad.
  always_comb begin
    ph_data      = (pay_rem != '0);
    ph_crc       = !ph_data && (crc_rem != '0);
    ph_pad       = !ph_data && !ph_crc;
    out_free     = !out_valid || out_ready;
    info_from_in = cfg_tx ? ph_data : !cfg_fec;
    info_step    = (state == S_INFO) && out_free && (!info_from_in || in_valid);
    par_step     = (state == S_PARITY) && out_free;
    col_step     = (state == S_COLLECT) && in_valid;
    drain_done   = (state == S_DRAIN) && out_free;
    blk_last     = cfg_fec && (blk_cnt == CNT_W'(FEC_K - 1));
    info_left    = ph_data || ph_crc || (cfg_fec && (blk_cnt != '0));
    pay_rem_n    = pay_rem - LEN_W'(ph_data);
    crc_rem_n    = crc_rem - CRC_CW'(ph_crc);
    info_left_n  = (pay_rem_n != '0) || (crc_rem_n != '0) || (cfg_fec && !blk_last);
    if (cfg_tx) raw_bit = ph_data ? in_bit : (ph_crc && crc_r[CRC_W-1]);
    else        raw_bit = cfg_fec ? cw[FEC_N-1] : in_bit;
    // Pad bits bypass the whitener and do not advance it.
    wht_bit      = cfg_wht && !ph_pad && wht_r[WHT_W-1];
    info_x       = raw_bit ^ wht_bit;
    emit         = cfg_tx || ph_data;
    pkt_empty    = (pay_len == '0) && !crc_en;
  end

  // Syndrome lookup: a single error at arrival index i (buffer position N-1-i) gives
  // syndrome x^(N-1-i) mod g, so walk the powers of x and flip the matching position.
  always_comb begin
    syn       = fec_r ^ par_r;
    pw        = FEC_P'(1);
    flip_hit  = 1'b0;
    flip_mask = '0;
    for (int j = 0; j < FEC_N; j++) begin
      if (!flip_hit && (syn != '0) && (pw == syn)) begin
        flip_hit  = 1'b1;
        flip_mask = FEC_N'(1) << j;
      end
      pw = {pw[FEC_P-2:0], 1'b0} ^ (pw[FEC_P-1] ? FEC_POLY : '0);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_6M) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (start && !pkt_empty) state_nxt = (!mode_tx && fec_en) ? S_COLLECT : S_INFO;
      S_INFO:
        if (info_step) begin
          if (blk_last)          state_nxt = cfg_tx ? S_PARITY : (info_left_n ? S_COLLECT : S_DRAIN);
          else if (!info_left_n) state_nxt = S_DRAIN;
        end
      S_PARITY:
        if (par_step && (par_cnt == CNT_W'(FEC_P - 1))) state_nxt = info_left ? S_INFO : S_DRAIN;
      S_COLLECT:
        if (col_step && (col_cnt == CNT_W'(FEC_N - 1))) state_nxt = S_SYN;
      S_SYN:
        state_nxt = S_INFO;
      S_DRAIN:
        if (drain_done) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    in_ready  = (state == S_COLLECT) || ((state == S_INFO) && info_from_in && out_free);
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // Datapath: everything advances only on an accepted step, so backpressure freezes it.
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      {cfg_tx, cfg_crc, cfg_wht, cfg_fec} <= '0;
      crc_r <= '0; wht_r <= '0; fec_r <= '0; par_r <= '0; cw <= '0;
      pay_rem <= '0; crc_rem <= '0; blk_cnt <= '0; par_cnt <= '0; col_cnt <= '0;
      out_valid <= 1'b0; out_bit <= 1'b0; done <= 1'b0; crc_ok <= 1'b0;
      fec_corr_cnt <= '0; fec_uncorr <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == S_IDLE) && start) begin
        {cfg_tx, cfg_crc, cfg_wht, cfg_fec} <= {mode_tx, crc_en, wht_en, fec_en};
        crc_r <= crc_init; wht_r <= wht_init; fec_r <= '0; par_r <= '0; cw <= '0;
        pay_rem <= pay_len; crc_rem <= crc_en ? CRC_CW'(CRC_W) : '0;
        blk_cnt <= '0; par_cnt <= '0; col_cnt <= '0;
        fec_corr_cnt <= '0; fec_uncorr <= 1'b0;
        crc_ok <= 1'b0;
        if (pkt_empty) begin
          done   <= 1'b1;
          crc_ok <= !mode_tx;
        end
      end

      if (info_step) begin
        pay_rem <= pay_rem_n;
        crc_rem <= crc_rem_n;
        if (cfg_fec) blk_cnt <= blk_last ? '0 : blk_cnt + CNT_W'(1);
        if (cfg_wht && !ph_pad) wht_r <= wht_next(wht_r);
        if (cfg_tx) begin
          // TX CRC covers the unwhitened payload, then shifts its remainder out.
          if (ph_data)     crc_r <= crc_next(crc_r, raw_bit);
          else if (ph_crc) crc_r <= {crc_r[CRC_W-2:0], 1'b0};
          if (cfg_fec) fec_r <= fec_next(fec_r, info_x);
        end else begin
          if (!ph_pad) crc_r <= crc_next(crc_r, info_x);
          if (cfg_fec) cw <= {cw[FEC_N-2:0], 1'b0};
        end
      end

      if (par_step) begin
        fec_r   <= (par_cnt == CNT_W'(FEC_P - 1)) ? '0 : {fec_r[FEC_P-2:0], 1'b0};
        par_cnt <= (par_cnt == CNT_W'(FEC_P - 1)) ? '0 : par_cnt + CNT_W'(1);
      end

      if (col_step) begin
        cw <= {cw[FEC_N-2:0], in_bit};
        if (col_cnt < CNT_W'(FEC_K)) fec_r <= fec_next(fec_r, in_bit);
        else                         par_r <= {par_r[FEC_P-2:0], in_bit};
        col_cnt <= (col_cnt == CNT_W'(FEC_N - 1)) ? '0 : col_cnt + CNT_W'(1);
      end

      if (state == S_SYN) begin
        cw    <= cw ^ flip_mask;
        fec_r <= '0;
        if (syn != '0) begin
          if (!flip_hit)                   fec_uncorr   <= 1'b1;
          else if (fec_corr_cnt != 8'hFF)  fec_corr_cnt <= fec_corr_cnt + 8'd1;
        end
      end

      if (info_step && emit) begin
        out_valid <= 1'b1;
        out_bit   <= info_x;
      end else if (par_step) begin
        out_valid <= 1'b1;
        out_bit   <= fec_r[FEC_P-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (drain_done) begin
        done   <= 1'b1;
        crc_ok <= !cfg_tx && (!cfg_crc || (crc_r == '0));
      end
    end
  end
endmodule
